serial_frame_rx_msb: RTL and testbench
======================================

// Module: serial_frame_rx_msb
// PURPOSE
// Serial frame receiver and deserializer, MSB first. It is the receive-side partner of the team's
// MSB-first PISO transmitter. Frame: idle line '1', one start bit '0', DATA_W data bits MSB first,
// one stop bit '1'. It oversamples rxd on the smp_tick enable, validates start and stop bits, and
// delivers each parallel word with a one-cycle valid strobe. It sits between the pad and the
// consumer logic.
// PARAMETERS
// DATA_W       8   data bits per frame (>=2)
// OSR         16   smp_tick pulses per bit period (even, >=4)
// SYNC_STAGES  2   flops in the rxd synchronizer (>=2)
// PORTS
// clk         in   1        system clock
// reset       in   1        asynchronous reset, active-low
// smp_tick    in   1        one-clk strobe at OSR x bit rate; all sampling advances only on it
// rxd         in   1        asynchronous serial line, idle high
// clr_err     in   1        synchronous clear of frame_err
// data_out    out  DATA_W   last good received word (MSB = first data bit on the line)
// data_valid  out  1        1-clk pulse: data_out just updated
// frame_err   out  1        sticky: stop bit sampled '0'
// busy        out  1        high in any state other than IDLE
// BEHAVIOUR
// - Reset (async, reset=0): synchronizer flops='1', state=IDLE, counters=0, shift reg=0,
//   data_out=0, data_valid=0, frame_err=0, busy=0. Reset mid-frame aborts the frame, and no
//   output updates from it.
// - rxd passes through SYNC_STAGES flops -> rxd_s. All decisions use rxd_s only.
// - tick_cnt counts 0..OSR-1. bit_cnt counts 0..DATA_W-1. Both change only on clk edges where
//   smp_tick=1. If no tick arrives, the state holds.
// - FSM: IDLE, START, DATA, STOP, BREAK.
//   IDLE:  on tick with rxd_s=0 -> START, tick_cnt=0.
//   START: on tick, tick_cnt++. At tick_cnt==OSR/2-1 sample rxd_s:
//          '1' = glitch -> IDLE, no flags.
//          '0' -> DATA, tick_cnt=0, bit_cnt=0.
//   DATA:  on tick, tick_cnt++. At tick_cnt==OSR-1 (mid-bit):
//          shreg <= {shreg[DATA_W-2:0], rxd_s}, tick_cnt=0, bit_cnt++.
//          After the DATA_W-th sample -> STOP.
//   STOP:  at tick_cnt==OSR-1 sample rxd_s:
//          '1' -> data_out<=shreg, data_valid=1 on the next clk, -> IDLE.
//          '0' -> frame_err=1, data_out unchanged, no valid, -> BREAK.
//   BREAK: stay until a tick with rxd_s=1 -> IDLE. This blocks false starts on a held-low line.
// - Latency: data_valid rises 1 clk after the stop-bit sampling tick. It is high exactly 1 clk,
//   even if smp_tick is held high.
// - Back-to-back: STOP->IDLE happens mid-stop-bit. A start edge in the second half of the stop
//   bit is detected normally.
// - frame_err: set on a bad stop bit and held until clr_err=1. If clr_err and a new error occur
//   in the same cycle, set wins.
// - busy = (state != IDLE), registered with the state.
// - Only bit_cnt/tick_cnt compares end the frame. No wrap past DATA_W is possible, and the
//   counters return to 0 on each state entry.
// TESTING
// 1 OSR=16, frame 0,1,0,1,0,0,1,0,1,1 (0xA5) -> data_out=8'hA5, data_valid 1 clk, frame_err=0,
//   busy low after the stop sample.
// 2 rxd low for 4 ticks then high -> START aborts at tick 7, returns to IDLE; no valid, no error.
// 3 0x3C frame with stop bit '0' -> frame_err=1, data_out keeps its prior value, state BREAK;
//   rxd high -> IDLE; clr_err pulse -> frame_err=0.
// 4 back-to-back 0x00 then 0xFF, next start at tick 9 of the stop bit -> two valid pulses,
//   values 00 then FF.
// 5 reset asserted in DATA bit 4 of 0x81 -> all outputs 0 at once; next clean frame 0x81
//   received correctly.
// 6 smp_tick gated off for 50 clks mid-DATA -> state, counters and outputs frozen;
//   frame completes correctly after ticks resume.

Source files
------------

// File: rtl/serial_frame_rx_msb.sv
// MSB-first serial frame receiver: oversampled start/data/stop decoding with
// a stop-bit framing check and a one-cycle valid strobe per good word.
module serial_frame_rx_msb #(
  parameter int DATA_W      = 8,
  parameter int OSR         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              smp_tick,
  input  logic              rxd,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = $clog2(OSR);
  localparam int BW = $clog2(DATA_W);
  localparam logic [CW-1:0] TICK_HALF = CW'(OSR/2 - 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(OSR - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t                 state, nxt_state;
  logic [CW-1:0]          tick_cnt, nxt_tick;
  logic [BW-1:0]          bit_cnt, nxt_bit;
  logic [DATA_W-1:0]      shreg, nxt_shreg;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rxd_s, load_out, set_err;

  // Synchronizer resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= '1;
    else        sync <= {sync[SYNC_STAGES-2:0], rxd};
  end
  assign rxd_s = sync[SYNC_STAGES-1];

  always_comb begin
    nxt_state = state;
    nxt_tick  = tick_cnt;
    nxt_bit   = bit_cnt;
    nxt_shreg = shreg;
    load_out  = 1'b0;
    set_err   = 1'b0;
    if (smp_tick) begin
      case (state)
        IDLE: if (!rxd_s) begin
          nxt_state = START;
          nxt_tick  = '0;
        end
        START: if (tick_cnt == TICK_HALF) begin
          nxt_tick  = '0;
          nxt_bit   = '0;
          nxt_state = rxd_s ? IDLE : DATA;
        end else begin
          nxt_tick = tick_cnt + CW'(1);
        end
        DATA: if (tick_cnt == TICK_LAST) begin
          nxt_shreg = {shreg[DATA_W-2:0], rxd_s};
          nxt_tick  = '0;
          if (bit_cnt == BIT_LAST) begin
            nxt_bit   = '0;
            nxt_state = STOP;
          end else begin
            nxt_bit = bit_cnt + BW'(1);
          end
        end else begin
          nxt_tick = tick_cnt + CW'(1);
        end
        STOP: if (tick_cnt == TICK_LAST) begin
          nxt_tick = '0;
          if (rxd_s) begin
            nxt_state = IDLE;
            load_out  = 1'b1;
          end else begin
            nxt_state = BREAK;
            set_err   = 1'b1;
          end
        end else begin
          nxt_tick = tick_cnt + CW'(1);
        end
        // Held-low line must return high before a new start is accepted.
        BREAK: if (rxd_s) begin
          nxt_state = IDLE;
          nxt_tick  = '0;
        end
        default: begin
          nxt_state = IDLE;
          nxt_tick  = '0;
          nxt_bit   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= nxt_state;
      tick_cnt   <= nxt_tick;
      bit_cnt    <= nxt_bit;
      shreg      <= nxt_shreg;
      data_valid <= load_out;
      busy       <= (nxt_state != IDLE);
      if (load_out) data_out <= shreg;
      if (set_err)      frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_frame_rx_msb.sv
// Directed bench for serial_frame_rx_msb; good words are queued when sent and
// matched against each data_valid strobe.
module tb_serial_frame_rx_msb;

  localparam int DATA_W = 8;
  localparam int OSR    = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              smp_tick;
  logic              rxd = 1'b1;
  logic              clr_err = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              data_valid, frame_err, busy;

  logic              tick_en = 1'b1;
  logic [1:0]        div = '0;
  logic [7:0]        exp_q[$];
  int                checks = 0;
  int                errors = 0;

  serial_frame_rx_msb #(.DATA_W(DATA_W), .OSR(OSR), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .smp_tick(smp_tick), .rxd(rxd), .clr_err(clr_err),
    .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) div <= div + 2'd1;
  assign smp_tick = tick_en && (div == 2'd3);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Rxd changes #1 after a tick edge, so each bit is seen by exactly OSR ticks.
  task automatic wait_tick();
    @(posedge clk);
    while (!smp_tick) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int n);
    rxd = b;
    repeat (n) wait_tick();
  endtask

  task automatic send_data(input logic [7:0] d);
    send_bit(1'b0, OSR);
    for (int i = 7; i >= 0; i--) send_bit(d[i], OSR);
  endtask

  always @(negedge clk) begin
    if (reset && data_valid) begin
      if (exp_q.size() == 0) chk("unexpected_valid", {24'd0, data_out}, 32'hFFFF_FFFF);
      else chk("rx_word", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_data_out", {24'd0, data_out}, 0);
    chk("rst_valid", {31'd0, data_valid}, 0);
    chk("rst_frame_err", {31'd0, frame_err}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) wait_tick();

    // 1: 0xA5 with exact valid timing
    exp_q.push_back(8'hA5);
    send_data(8'hA5);
    rxd = 1'b1;
    repeat (8) wait_tick();
    chk("t1_pre_valid", {31'd0, data_valid}, 0);
    chk("t1_busy_stop", {31'd0, busy}, 1);
    wait_tick();
    chk("t1_valid", {31'd0, data_valid}, 1);
    chk("t1_busy_low", {31'd0, busy}, 0);
    @(posedge clk); #1;
    chk("t1_valid_pulse", {31'd0, data_valid}, 0);
    chk("t1_frame_err", {31'd0, frame_err}, 0);
    repeat (7) wait_tick();

    // 2: glitch on start bit
    send_bit(1'b0, 4);
    chk("t2_busy", {31'd0, busy}, 1);
    send_bit(1'b1, 8);
    chk("t2_idle", {31'd0, busy}, 0);
    chk("t2_no_err", {31'd0, frame_err}, 0);
    chk("t2_data_kept", {24'd0, data_out}, 32'hA5);

    // 3: bad stop bit, break, clear
    send_data(8'h3C);
    send_bit(1'b0, 9);
    chk("t3_frame_err", {31'd0, frame_err}, 1);
    chk("t3_data_kept", {24'd0, data_out}, 32'hA5);
    send_bit(1'b0, 20);
    chk("t3_break_busy", {31'd0, busy}, 1);
    send_bit(1'b1, 2);
    chk("t3_break_exit", {31'd0, busy}, 0);
    chk("t3_err_sticky", {31'd0, frame_err}, 1);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    chk("t3_err_clr", {31'd0, frame_err}, 0);
    repeat (4) wait_tick();

    // 4: back-to-back, next start right after the stop sample
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_data(8'h00);
    send_bit(1'b1, 9);
    send_data(8'hFF);
    send_bit(1'b1, OSR);
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_last", {24'd0, data_out}, 32'hFF);

    // 5: reset during data bit 4 of 0x81
    send_bit(1'b0, OSR);
    send_bit(1'b1, OSR);
    send_bit(1'b0, OSR);
    send_bit(1'b0, OSR);
    send_bit(1'b0, OSR);
    send_bit(1'b0, 8);
    reset = 1'b0;
    #1;
    chk("t5_data_out", {24'd0, data_out}, 0);
    chk("t5_valid", {31'd0, data_valid}, 0);
    chk("t5_frame_err", {31'd0, frame_err}, 0);
    chk("t5_busy", {31'd0, busy}, 0);
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) wait_tick();
    exp_q.push_back(8'h81);
    send_data(8'h81);
    send_bit(1'b1, OSR);
    chk("t5_recover", {24'd0, data_out}, 32'h81);

    // 6: ticks gated off mid-data
    exp_q.push_back(8'h5A);
    send_bit(1'b0, OSR);
    send_bit(1'b0, OSR);
    send_bit(1'b1, OSR);
    send_bit(1'b0, OSR);
    send_bit(1'b1, 8);
    tick_en = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("t6_frozen_busy", {31'd0, busy}, 1);
    chk("t6_frozen_data", {24'd0, data_out}, 32'h81);
    chk("t6_frozen_err", {31'd0, frame_err}, 0);
    tick_en = 1'b1;
    wait_tick();
    repeat (7) wait_tick();
    send_bit(1'b1, OSR);
    send_bit(1'b0, OSR);
    send_bit(1'b1, OSR);
    send_bit(1'b0, OSR);
    send_bit(1'b1, OSR);
    chk("t6_word", {24'd0, data_out}, 32'h5A);
    chk("t6_idle", {31'd0, busy}, 0);
    chk("final_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
